// File: rtl/logic_unit_nb.sv
// Registered N-bit bitwise logic unit with stream-accumulate mode and an output FIFO.
// Latency 1 cycle accept->out_valid; in_ready = !full. Define LOGIC_UNIT_PARITY_EN to add out_parity.

module logic_unit_nb_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 2
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          push,
   input  logic [W-1:0]                  push_data,
   input  logic                          pop,
   output logic [W-1:0]                  pop_data,
   output logic                          full,
   output logic                          empty,
   output logic [$clog2(DEPTH+1)-1:0]    count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] cnt;
   logic [W-1:0]  hold;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
         hold   <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         // Remember the departing head so the output is stable once empty.
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
            hold   <= mem[rd_ptr];
         end
         case ({push, pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

   assign full     = (cnt == CW'(DEPTH));
   assign empty    = (cnt == '0);
   assign count    = cnt;
   assign pop_data = empty ? hold : mem[rd_ptr];
endmodule

module logic_unit_nb #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 2
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [WIDTH-1:0]              x,
   input  logic [WIDTH-1:0]              y,
   input  logic [2:0]                    op,
   input  logic                          acc,
   input  logic                          in_last,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [WIDTH-1:0]              out_data,
   output logic                          out_zero,
   output logic [$clog2(DEPTH+1)-1:0]    count
`ifdef LOGIC_UNIT_PARITY_EN
   ,output logic                         out_parity
`endif
);
`ifdef LOGIC_UNIT_PARITY_EN
   localparam int EW = WIDTH + 2;
`else
   localparam int EW = WIDTH + 1;
`endif

   function automatic logic [WIDTH-1:0] apply_op(input logic [2:0] o,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
      case (o)
         3'b000:  return a & b;
         3'b001:  return a | b;
         3'b010:  return a ^ b;
         3'b011:  return ~(a & b);
         3'b100:  return ~(a | b);
         3'b101:  return ~(a ^ b);
         3'b110:  return ~a;
         default: return a;
      endcase
   endfunction

   logic [WIDTH-1:0] acc_reg;
   logic             busy;
   logic [WIDTH-1:0] opa;
   logic [WIDTH-1:0] opb;
   logic [WIDTH-1:0] result;
   logic             accept;
   logic             push;
   logic             pop;
   logic             full;
   logic             empty;
   logic [EW-1:0]    entry;
   logic [EW-1:0]    head;

   // A fresh accumulation uses x as both operands, which yields the single-operand rules.
   always_comb begin
      opa    = (acc && busy) ? acc_reg : x;
      opb    = acc ? x : y;
      result = apply_op(op, opa, opb);
   end

   assign in_ready  = ~full;
   assign out_valid = ~empty;
   assign accept    = in_valid & in_ready;
   assign push      = accept & (~acc | in_last);
   assign pop       = out_valid & out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_reg <= '0;
         busy    <= 1'b0;
      end else if (accept && acc) begin
         acc_reg <= result;
         busy    <= ~in_last;
      end
   end

`ifdef LOGIC_UNIT_PARITY_EN
   assign entry      = {^result, ~|result, result};
   assign out_parity = head[WIDTH+1];
`else
   assign entry = {~|result, result};
`endif

   logic_unit_nb_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_data (entry),
      .pop       (pop),
      .pop_data  (head),
      .full      (full),
      .empty     (empty),
      .count     (count)
   );

   assign out_data = head[WIDTH-1:0];
   assign out_zero = head[WIDTH];
endmodule

// File: tb/tb_logic_unit_nb.sv
// Bench for logic_unit_nb: directed literal checks plus randomized traffic against a truth-table queue model.
module tb_logic_unit_nb;
   localparam int W  = 4;
   localparam int D  = 2;
   localparam int CW = $clog2(D+1);

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  x, y;
   logic [2:0]    op;
   logic          acc, in_last;
   logic          out_valid, out_ready;
   logic [W-1:0]  out_data;
   logic          out_zero;
   logic [CW-1:0] count;
`ifdef LOGIC_UNIT_PARITY_EN
   logic          out_parity;
`endif

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   logic_unit_nb #(.WIDTH(W), .DEPTH(D)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .x(x), .y(y), .op(op), .acc(acc), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_zero(out_zero), .count(count)
`ifdef LOGIC_UNIT_PARITY_EN
      , .out_parity(out_parity)
`endif
   );

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-bit truth table indexed by {a,b}.
   function automatic logic [W-1:0] m_op(input logic [2:0] o, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
      logic [3:0]   tt;
      logic [W-1:0] r;
      case (o)
         3'd0: tt = 4'b1000;
         3'd1: tt = 4'b1110;
         3'd2: tt = 4'b0110;
         3'd3: tt = 4'b0111;
         3'd4: tt = 4'b0001;
         3'd5: tt = 4'b1001;
         3'd6: tt = 4'b0011;
         default: tt = 4'b1100;
      endcase
      for (int i = 0; i < W; i++) r[i] = tt[{a[i], b[i]}];
      return r;
   endfunction

   logic [W-1:0] m_q[$];
   logic [W-1:0] m_last;
   logic         m_last_zero;
   logic         m_last_par;
   logic [W-1:0] m_acc;
   logic         m_busy;

   always @(posedge clk) begin
      logic         do_pop, do_acc;
      logic [W-1:0] r;
      if (!rst_n) begin
         m_q.delete();
         m_last = '0; m_last_zero = 1'b0; m_last_par = 1'b0;
         m_acc = '0; m_busy = 1'b0;
      end else begin
         do_pop = (m_q.size() != 0) && out_ready;
         do_acc = in_valid && (m_q.size() < D);
         if (do_pop) begin
            m_last      = m_q.pop_front();
            m_last_zero = (m_last == '0);
            m_last_par  = ^m_last;
         end
         if (do_acc) begin
            if (!acc) m_q.push_back(m_op(op, x, y));
            else begin
               r = m_busy ? m_op(op, m_acc, x) : m_op(op, x, x);
               m_acc = r;
               m_busy = !in_last;
               if (in_last) m_q.push_back(r);
            end
         end
      end
   end

   always @(posedge clk) begin
      #2;
      chk("in_ready", int'(in_ready), int'(m_q.size() < D));
      chk("out_valid", int'(out_valid), int'(m_q.size() != 0));
      chk("count", int'(count), m_q.size());
      if (m_q.size() != 0) begin
         chk("out_data", int'(out_data), int'(m_q[0]));
         chk("out_zero", int'(out_zero), int'(m_q[0] == '0));
`ifdef LOGIC_UNIT_PARITY_EN
         chk("out_parity", int'(out_parity), int'(^m_q[0]));
`endif
      end else begin
         chk("held_data", int'(out_data), int'(m_last));
         chk("held_zero", int'(out_zero), int'(m_last_zero));
`ifdef LOGIC_UNIT_PARITY_EN
         chk("held_parity", int'(out_parity), int'(m_last_par));
`endif
      end
   end

   task automatic drive(input logic v, input logic [W-1:0] xi, input logic [W-1:0] yi,
                        input logic [2:0] o, input logic a, input logic l, input logic r);
      @(negedge clk);
      in_valid = v; x = xi; y = yi; op = o; acc = a; in_last = l; out_ready = r;
      @(posedge clk);
      #2;
   endtask

   logic [W-1:0] sweep [8];

   initial begin
      sweep = '{4'b1000, 4'b1110, 4'b0110, 4'b0111, 4'b0001, 4'b1001, 4'b0011, 4'b1100};
      rst_n = 1'b0; in_valid = 1'b0; x = '0; y = '0; op = '0;
      acc = 1'b0; in_last = 1'b0; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      chk("rst_count", int'(count), 0);
      chk("rst_valid", int'(out_valid), 0);
      chk("rst_data", int'(out_data), 0);
      chk("rst_zero", int'(out_zero), 0);
      chk("rst_ready", int'(in_ready), 1);
      @(negedge clk) rst_n = 1'b1;

      drive(1, 4'b0001, 4'b0000, 3'b001, 0, 0, 0);
      chk("t1_valid", int'(out_valid), 1);
      chk("t1_data", int'(out_data), 4'b0001);
      chk("t1_zero", int'(out_zero), 0);
      chk("t1_count", int'(count), 1);
      drive(0, 0, 0, 0, 0, 0, 1);
      chk("t1_empty", int'(out_valid), 0);
      chk("t1_hold", int'(out_data), 4'b0001);

      for (int i = 0; i < 8; i++) begin
         drive(1, 4'b1100, 4'b1010, 3'(i), 0, 0, 1);
         chk("sweep", int'(out_data), int'(sweep[i]));
      end
      drive(0, 0, 0, 0, 0, 0, 1);

      drive(1, 4'b0001, 0, 3'b001, 1, 0, 0);
      chk("acc_nopush1", int'(count), 0);
      drive(1, 4'b0100, 0, 3'b001, 1, 0, 0);
      chk("acc_nopush2", int'(count), 0);
      drive(1, 4'b1000, 0, 3'b001, 1, 1, 0);
      chk("acc_or_count", int'(count), 1);
      chk("acc_or_data", int'(out_data), 4'b1101);
      drive(0, 0, 0, 0, 0, 0, 1);
      drive(1, 4'b1111, 0, 3'b000, 1, 0, 0);
      drive(1, 4'b0110, 0, 3'b000, 1, 1, 0);
      chk("acc_and_data", int'(out_data), 4'b0110);
      chk("acc_and_zero", int'(out_zero), 0);
      drive(0, 0, 0, 0, 0, 0, 1);

      drive(1, 4'b0001, 0, 3'b111, 0, 0, 0);
      drive(1, 4'b0010, 0, 3'b111, 0, 0, 0);
      drive(1, 4'b0100, 0, 3'b111, 0, 0, 0);
      chk("full_count", int'(count), 2);
      chk("full_ready", int'(in_ready), 0);
      chk("full_head", int'(out_data), 4'b0001);
      drive(0, 0, 0, 0, 0, 0, 1);
      chk("pop_head", int'(out_data), 4'b0010);
      chk("pop_ready", int'(in_ready), 1);
      chk("pop_count", int'(count), 1);
      drive(0, 0, 0, 0, 0, 0, 1);

      drive(1, 4'b0011, 0, 3'b001, 1, 0, 0);
      drive(1, 4'b0100, 0, 3'b001, 1, 0, 0);
      @(negedge clk) begin rst_n = 1'b0; in_valid = 1'b0; end
      @(posedge clk) #2;
      chk("abort_count", int'(count), 0);
      chk("abort_valid", int'(out_valid), 0);
      @(negedge clk) rst_n = 1'b1;
      drive(1, 4'b1010, 0, 3'b111, 1, 1, 0);
      chk("abort_fresh", int'(out_data), 4'b1010);
      drive(0, 0, 0, 0, 0, 0, 1);

`ifdef LOGIC_UNIT_PARITY_EN
      drive(1, 4'b0111, 0, 3'b111, 0, 0, 0);
      chk("parity_odd", int'(out_parity), 1);
      drive(1, 4'b0110, 0, 3'b111, 0, 0, 1);
      chk("parity_even", int'(out_parity), 0);
      drive(0, 0, 0, 0, 0, 0, 1);
`endif

      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         rst_n     = ($urandom_range(0, 299) != 0);
         in_valid  = ($urandom_range(0, 3) != 0);
         x         = W'($urandom);
         y         = W'($urandom);
         op        = 3'($urandom);
         acc       = 1'($urandom);
         in_last   = ($urandom_range(0, 2) == 0);
         out_ready = ($urandom_range(0, 9) < 6);
      end
      @(negedge clk) begin rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1; end
      repeat (4) @(posedge clk);
      #3;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
